// File: rtl/ps2_tx_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
// Holds the FSM state encoding, frame geometry and the parity rule.
package ps2_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam int FRAME_BITS = 11;

    // Odd parity: data ones plus parity bit always total an odd number.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous FIFO, registered count; read data is combinational from the head slot.
// Writes are refused while full even if a read happens on the same edge.
module ps2_tx_fifo #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full   = (count == (AW + 1)'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_vld & ~full;
    assign pop    = rd_en & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: queued bytes become 11-bit frames on registered clk/data lines.
// Start bit shows two edges after a push into an idle block; din_ready drops when the FIFO is full.
module ps2_kbd_tx
    import ps2_tx_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000,
    parameter int FIFO_AW     = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       overflow
);

    localparam int PH_W  = $clog2(2 * HALF_PERIOD);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(HALF_PERIOD);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_t             state, state_nxt;
    logic [FRAME_BITS-1:0] sh, sh_nxt;
    logic [3:0]            bit_idx, bit_nxt;
    logic [PH_W-1:0]       phase, ph_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_nxt;
    logic                  clk_nxt, data_nxt;

    logic                  pop;
    logic [7:0]            fifo_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_AW:0]      fifo_count;

    ps2_tx_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr_vld  (din_valid),
        .wr_dat  (din),
        .rd_en   (pop),
        .rd_dat  (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign din_ready = ~fifo_full;
    assign overflow  = din_valid & fifo_full;
    assign busy      = (state != IDLE) | (fifo_count != '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sh       <= '1;
            bit_idx  <= '0;
            phase    <= '0;
            gap_cnt  <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            bit_idx  <= bit_nxt;
            phase    <= ph_nxt;
            gap_cnt  <= gap_nxt;
            ps2_clk  <= clk_nxt;
            ps2_data <= data_nxt;
        end
    end

    // Line outputs are decoded from the current state and registered, so they trail it by one cycle.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        bit_nxt   = bit_idx;
        ph_nxt    = phase;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        clk_nxt   = 1'b1;
        data_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sh_nxt    = {1'b1, odd_parity(fifo_dat), fifo_dat, 1'b0};
                    bit_nxt   = '0;
                    ph_nxt    = '0;
                    state_nxt = FRAME;
                end
            end
            FRAME: begin
                clk_nxt  = (phase < PH_HALF);
                data_nxt = sh[bit_idx];
                if (phase == PH_LAST) begin
                    ph_nxt = '0;
                    if (bit_idx == BIT_LAST) begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                    end
                end else begin
                    ph_nxt = phase + PH_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
